// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and defaults for the RAM bus controller and its address check.
// State encoding is a 3-bit enum; MISALIGN_FAULT_EN is left undefined by default.
package mem_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DEF_RAM_WORDS   = 1024;
    localparam int DEF_WAIT_CYCLES = 0;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational range check (and, with MISALIGN_FAULT_EN, alignment check).
// Ports: iAddr (byte address) -> oFault (1 = access must be rejected).
module mem_addr_check
    import mem_bus_ctrl_pkg::*;
#(
    parameter int RAM_WORDS = DEF_RAM_WORDS
) (
    input  logic [31:0] iAddr,
    output logic        oFault
);

    // 33-bit limit so RAM_WORDS*4 == 2^32 cannot overflow the compare.
    localparam logic [32:0] LIMIT = 33'(RAM_WORDS) * 33'd4;

    logic range_bad;

    assign range_bad = ({1'b0, iAddr} >= LIMIT);

`ifdef MISALIGN_FAULT_EN
    assign oFault = range_bad | (iAddr[1:0] != 2'b00);
`else
    assign oFault = range_bad;
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// One-at-a-time CPU-to-RAM bus controller with one-cycle strobes, wait states
// and registered outputs. Ports: iClk/iRst (sync, high), CPU side iReq/iWe/
// iAddr/iWData -> oRData/oDone/oFault/oBusy; RAM side oMemRead/oMemWrite/
// oMemAddr/oMemData <- iMemData. Optional macro: MISALIGN_FAULT_EN.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int RAM_WORDS   = DEF_RAM_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic [31:0] oRData,
    output logic        oDone,
    output logic        oFault,
    output logic        oBusy,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemData,
    input  logic [31:0] iMemData
);

    localparam logic [3:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] rdata_d;
    logic        done_d, fault_d, busy_d;
    logic        rd_d, wr_d;
    logic [31:0] maddr_d, mdata_d;
    logic        addr_fault;

    mem_addr_check #(
        .RAM_WORDS (RAM_WORDS)
    ) u_chk (
        .iAddr  (iAddr),
        .oFault (addr_fault)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        rdata_d = oRData;
        done_d  = oDone;
        fault_d = oFault;
        rd_d    = oMemRead;
        wr_d    = oMemWrite;
        maddr_d = oMemAddr;
        mdata_d = oMemData;

        unique case (state_q)
            ST_IDLE: begin
                if (iReq) begin
                    we_d = iWe;
                    if (addr_fault) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        maddr_d = iAddr;
                        mdata_d = iWData;
                        rd_d    = !iWe;
                        wr_d    = iWe;
                    end
                end
            end
            ST_ACCESS: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
                if (WAIT_CYCLES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                // RAM output reflects the address held since ACCESS.
                if (!we_q) begin
                    rdata_d = iMemData;
                end
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                done_d  = 1'b0;
                fault_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                fault_d = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            oRData    <= 32'd0;
            oDone     <= 1'b0;
            oFault    <= 1'b0;
            oBusy     <= 1'b0;
            oMemRead  <= 1'b0;
            oMemWrite <= 1'b0;
            oMemAddr  <= 32'd0;
            oMemData  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            oRData    <= rdata_d;
            oDone     <= done_d;
            oFault    <= fault_d;
            oBusy     <= busy_d;
            oMemRead  <= rd_d;
            oMemWrite <= wr_d;
            oMemAddr  <= maddr_d;
            oMemData  <= mdata_d;
        end
    end

endmodule
